// File: rtl/ctr_incr_sched_pkg.sv
// ctr_sched_pkg: shared op encodings, default base address and channel indices
package ctr_sched_pkg;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_PINC = 2'b01, OP_MINC = 2'b10} op_e;
  localparam logic [11:0] ADDR_BASE_DEF = 12'o0032;
  localparam int CH_CDUX = 0;
  localparam int CH_CDUY = 1;
  localparam int CH_CDUZ = 2;
  localparam int CH_TRN = 3;
  localparam int CH_SHAFT = 4;
  localparam int CH_PIPX = 5;
  localparam int CH_PIPY = 6;
  localparam int CH_PIPZ = 7;
endpackage

// File: rtl/ctr_incr_sched_if.sv
// ctr_incr_sched_if: pulse inputs, sequencer strobe and grant outputs of the scheduler
interface ctr_incr_sched_if #(parameter int NCH = 8, parameter int AW = 12);
  logic [NCH-1:0] PLS;
  logic [NCH-1:0] MNS;
  logic TAKE;
  logic CTR_REQ;
  logic CTR_VLD;
  logic [AW-1:0] CTR_ADDR;
  logic [1:0] CTR_OP;
  logic [2*NCH-1:0] PEND;
  modport master(output PLS, MNS, TAKE, input CTR_REQ, CTR_VLD, CTR_ADDR, CTR_OP, PEND);
  modport slave(input PLS, MNS, TAKE, output CTR_REQ, CTR_VLD, CTR_ADDR, CTR_OP, PEND);
endinterface

// File: rtl/ctr_incr_sched_cell.sv
// ctr_req_cell: per-channel edge detect, pending plus/minus bits and cancellation
module ctr_req_cell (
  input  logic CLOCK,
  input  logic rst,
  input  logic pls,
  input  logic mns,
  input  logic clr,
  output logic pp,
  output logic pm,
  output logic elig,
  output logic dir,
  output logic nxt_elig
);
  logic prev_p, prev_m, cancel, pp_n, pm_n;
  assign cancel = pp & pm;
  assign pp_n = (pp & ~(cancel | clr)) | (pls & ~prev_p);
  assign pm_n = (pm & ~(cancel | clr)) | (mns & ~prev_m);
  assign elig = pp ^ pm;
  assign dir = pp;
  assign nxt_elig = pp_n ^ pm_n;
  // prev resets high so a level held through reset is not seen as an edge
  always_ff @(posedge CLOCK or posedge rst)
    if (rst) begin
      prev_p <= 1'b1;
      prev_m <= 1'b1;
      pp <= 1'b0;
      pm <= 1'b0;
    end else begin
      prev_p <= pls;
      prev_m <= mns;
      pp <= pp_n;
      pm <= pm_n;
    end
endmodule

// File: rtl/ctr_incr_sched.sv
// ctr_incr_sched: fixed-priority grant of pending counter increments to the sequencer
module ctr_incr_sched
  import ctr_sched_pkg::*;
#(
  parameter int NCH = 8,
  parameter int AW = 12,
  parameter logic [AW-1:0] ADDR_BASE = AW'(ADDR_BASE_DEF)
) (
  input logic CLOCK,
  input logic rst,
  ctr_incr_sched_if.slave bus
);
  localparam int SW = $clog2(NCH);
  logic [NCH-1:0] pp, pm, elig, dir, nelig, clr;
  logic [SW-1:0] sel;
  logic grant;
  for (genvar g = 0; g < NCH; g++) begin : g_cell
    ctr_req_cell u_cell (
      .CLOCK(CLOCK), .rst(rst), .pls(bus.PLS[g]), .mns(bus.MNS[g]), .clr(clr[g]),
      .pp(pp[g]), .pm(pm[g]), .elig(elig[g]), .dir(dir[g]), .nxt_elig(nelig[g])
    );
  end
  assign grant = bus.TAKE & |elig;
  assign clr = grant ? elig & (~elig + NCH'(1)) : '0;
  assign bus.PEND = {pm, pp};
  // lowest-index eligible channel wins
  always_comb begin
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--) if (elig[i]) sel = i[SW-1:0];
  end
  // registered grant strobe, address, op and request flag
  always_ff @(posedge CLOCK or posedge rst)
    if (rst) begin
      bus.CTR_REQ <= 1'b0;
      bus.CTR_VLD <= 1'b0;
      bus.CTR_OP <= OP_NONE;
      bus.CTR_ADDR <= '0;
    end else begin
      bus.CTR_REQ <= |nelig;
      bus.CTR_VLD <= grant;
      bus.CTR_OP <= !grant ? OP_NONE : dir[sel] ? OP_PINC : OP_MINC;
      if (grant) bus.CTR_ADDR <= ADDR_BASE + AW'(sel);
    end
endmodule

// File: tb/tb_ctr_incr_sched.sv
// tb_ctr_incr_sched: directed checks of edge capture, priority, cancellation and reset
module tb_ctr_incr_sched;
  import ctr_sched_pkg::*;
  logic CLOCK = 1'b0;
  logic rst;
  int errs = 0;
  int n = 0;
  ctr_incr_sched_if bus ();
  ctr_incr_sched dut (.CLOCK(CLOCK), .rst(rst), .bus(bus));
  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [11:0] addr, input logic [1:0] op);
    chk({tag, ".vld"}, 32'(bus.CTR_VLD), 32'(vld));
    chk({tag, ".addr"}, 32'(bus.CTR_ADDR), 32'(addr));
    chk({tag, ".op"}, 32'(bus.CTR_OP), 32'(op));
  endtask

  initial begin
    rst = 1'b1;
    bus.PLS = 8'h01;
    bus.MNS = 8'h00;
    bus.TAKE = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 12'o0000, 2'b00);
    chk("reset.req", 32'(bus.CTR_REQ), 32'd0);
    chk("reset.pend", 32'(bus.PEND), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    bus.PLS = 8'h00;
    tick();
    chk("held_high.pend", 32'(bus.PEND), 32'h0);
    chk("held_high.req", 32'(bus.CTR_REQ), 32'd0);

    bus.MNS[CH_TRN] = 1'b1;
    tick();
    chk("single.pend", 32'(bus.PEND), 32'h0800);
    chk("single.req", 32'(bus.CTR_REQ), 32'd1);
    bus.MNS = 8'h00;
    tick();
    tick();
    bus.TAKE = 1'b1;
    tick();
    bus.TAKE = 1'b0;
    chk_out("single.grant", 1'b1, 12'o0035, 2'b10);
    chk("single.req_after", 32'(bus.CTR_REQ), 32'd0);
    chk("single.pend_after", 32'(bus.PEND), 32'h0);
    tick();
    chk_out("single.idle", 1'b0, 12'o0035, 2'b00);

    bus.PLS = 8'h22;
    bus.MNS = 8'h80;
    tick();
    bus.PLS = 8'h00;
    bus.MNS = 8'h00;
    chk("prio.pend", 32'(bus.PEND), 32'h8022);
    bus.TAKE = 1'b1;
    tick();
    chk_out("prio.g1", 1'b1, 12'o0033, 2'b01);
    chk("prio.req1", 32'(bus.CTR_REQ), 32'd1);
    tick();
    chk_out("prio.g2", 1'b1, 12'o0037, 2'b01);
    tick();
    chk_out("prio.g3", 1'b1, 12'o0041, 2'b10);
    chk("prio.req3", 32'(bus.CTR_REQ), 32'd0);
    tick();
    chk_out("prio.g4", 1'b0, 12'o0041, 2'b00);
    chk("prio.pend4", 32'(bus.PEND), 32'h0);
    bus.TAKE = 1'b0;

    bus.PLS[CH_CDUZ] = 1'b1;
    bus.MNS[CH_CDUZ] = 1'b1;
    tick();
    chk("cancel.pend_both", 32'(bus.PEND), 32'h0404);
    chk("cancel.req0", 32'(bus.CTR_REQ), 32'd0);
    bus.PLS = 8'h00;
    bus.MNS = 8'h00;
    bus.TAKE = 1'b1;
    tick();
    bus.TAKE = 1'b0;
    chk_out("cancel.nogrant", 1'b0, 12'o0041, 2'b00);
    chk("cancel.pend", 32'(bus.PEND), 32'h0);
    chk("cancel.req1", 32'(bus.CTR_REQ), 32'd0);

    bus.PLS[CH_SHAFT] = 1'b1;
    tick();
    bus.PLS = 8'h00;
    tick();
    chk("eclr.pend0", 32'(bus.PEND), 32'h0010);
    bus.PLS[CH_SHAFT] = 1'b1;
    bus.TAKE = 1'b1;
    tick();
    bus.PLS = 8'h00;
    chk_out("eclr.g1", 1'b1, 12'o0036, 2'b01);
    chk("eclr.pend1", 32'(bus.PEND), 32'h0010);
    chk("eclr.req1", 32'(bus.CTR_REQ), 32'd1);
    tick();
    bus.TAKE = 1'b0;
    chk_out("eclr.g2", 1'b1, 12'o0036, 2'b01);
    chk("eclr.pend2", 32'(bus.PEND), 32'h0);
    chk("eclr.req2", 32'(bus.CTR_REQ), 32'd0);

    bus.PLS = 8'h01;
    bus.MNS = 8'h40;
    tick();
    bus.TAKE = 1'b1;
    tick();
    bus.TAKE = 1'b0;
    chk_out("mid.grant", 1'b1, 12'o0032, 2'b01);
    chk("mid.pend", 32'(bus.PEND), 32'h4000);
    #2 rst = 1'b1;
    #1;
    chk_out("mid.async", 1'b0, 12'o0000, 2'b00);
    chk("mid.async_pend", 32'(bus.PEND), 32'h0);
    chk("mid.async_req", 32'(bus.CTR_REQ), 32'd0);
    tick();
    rst = 1'b0;
    bus.PLS = 8'h00;
    bus.MNS = 8'h00;
    tick();
    chk("mid.after_pend", 32'(bus.PEND), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end
endmodule
